// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx
//  Purpose  : Parallel-to-serial frame transmitter, LSB first, with a
//             ready/valid word input and back-to-back frame support.
//             Define SERIAL_TX_PARITY_EN to append an even-parity bit.
//  Revision : 1.0  initial release
// ============================================================================
module serial_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int               c_CW   = $clog2(WIDTH);
  localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0]  c_ONE  = c_CW'(1);
`ifndef SERIAL_TX_PARITY_EN
  localparam logic [c_CW-1:0]  c_PENULT = c_CW'(WIDTH - 2);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SERIAL_TX_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_t;

  state_t           r_state;
  logic [c_CW-1:0]  r_count;
  logic [WIDTH-1:0] r_buf;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_last;
`ifdef SERIAL_TX_PARITY_EN
  logic             r_parity;
`endif

  logic w_ready;
  logic w_accept;

  // Ready while idle and on the final frame bit so frames can run back to back.
  assign w_ready  = (r_state == IDLE) || r_last;
  assign w_accept = din_valid && w_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_buf        <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_last       <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state      <= SHIFT;
      r_count      <= '0;
      r_buf        <= din >> 1;
      r_sout       <= din[0];
      r_sout_valid <= 1'b1;
      r_last       <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_parity     <= ^din;
`endif
    end else begin
      case (r_state)
        SHIFT: begin
          if (r_count == c_LAST) begin
            r_count <= '0;
`ifdef SERIAL_TX_PARITY_EN
            r_state <= PARITY;
            r_sout  <= r_parity;
            r_last  <= 1'b1;
`else
            r_state      <= IDLE;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_last       <= 1'b0;
`endif
          end else begin
            r_count <= r_count + c_ONE;
            r_sout  <= r_buf[0];
            r_buf   <= r_buf >> 1;
`ifndef SERIAL_TX_PARITY_EN
            r_last  <= (r_count == c_PENULT);
`endif
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          r_state      <= IDLE;
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_last       <= 1'b0;
        end
`endif
        IDLE: begin
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_last       <= 1'b0;
        end
        default: begin
          r_state      <= IDLE;
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_last       <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready  = w_ready;
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign last       = r_last;
  assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire
